// File: rtl/qam16_tx_pkg.sv
// Shared types and constants for the 16-QAM frame scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package qam16_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        HEADER   = 2'd2,
        PAYLOAD  = 2'd3
    } tx_state_t;

    localparam logic [3:0] SYM_PRE_EVEN = 4'h3;
    localparam logic [3:0] SYM_PRE_ODD  = 4'hC;
    localparam logic [3:0] SYM_IDLE     = 4'h0;

    // x^7 + x^6 + 1: feedback is the XOR of state bits 6 and 5
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [6:0] LFSR_TAPS = 7'h60;

    // Either reseed, or advance the LFSR by one symbol (4 shifts).
    // The low nibble of the advanced state is the keystream for that symbol.
    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic reseed);
        logic [6:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            r = {r[5:0], ^(r & LFSR_TAPS)};
        end
        return reseed ? LFSR_SEED : r;
    endfunction

endpackage

// File: rtl/qam16_sym_timer.sv
// Free-running symbol timer, counts 0..CLK_DIV-1 and flags the last count.
// Latency: tick is combinational from the counter; first tick CLK_DIV-1 cycles after reset.
// Backpressure: none, never stalls.
module qam16_sym_timer #(
    parameter int unsigned CLK_DIV = 2000
) (
    input  logic CLK_50M,
    input  logic RST_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q;

    // wrap at CLK_DIV-1, runs in every scheduler state
    always_ff @(posedge CLK_50M or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q <= 16'd0;
        end else if (cnt_q == LAST) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/qam16_frame_sched.sv
// Frame scheduler: preamble, 2-symbol header (seq), payload; optional scrambler via QAM16_SCRAMBLER_EN.
// Latency: symbol decided on timer tick, presented with sym_stb one cycle later.
// Backpressure: source is polled once per payload slot; missing data becomes a fill symbol.
module qam16_frame_sched #(
    parameter int unsigned CLK_DIV      = 2000,
    parameter int unsigned PREAMBLE_LEN = 8,
    parameter int unsigned PAYLOAD_LEN  = 32
) (
    input  logic       CLK_50M,
    input  logic       RST_n,
    input  logic       start,
    input  logic       src_valid,
    input  logic [3:0] src_data,
    output logic       src_ready,
    output logic       sym_stb,
    output logic [3:0] sym_data,
    output logic       tx_active,
    output logic       tx_done,
    output logic       underrun
);

    import qam16_tx_pkg::*;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] PAY_LAST = 8'(PAYLOAD_LEN - 1);

    tx_state_t  state_q, state_nxt;
    logic [7:0] cnt_q, cnt_nxt;
    logic [7:0] seq_q, seq_nxt;
    logic [3:0] data_nxt;
    logic [3:0] raw_sym;
    logic [3:0] pay_sym;
    logic       active_nxt;
    logic       done_nxt;
    logic       under_nxt;
    logic       frame_start;
    logic       tick;

    qam16_sym_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .CLK_50M (CLK_50M),
        .RST_n   (RST_n),
        .tick    (tick)
    );

    // an absent source symbol becomes the fill symbol
    assign raw_sym = src_valid ? src_data : SYM_IDLE;

`ifdef QAM16_SCRAMBLER_EN
    logic [6:0] lfsr_q;
    logic [6:0] lfsr_adv;

    assign lfsr_adv = lfsr_next(lfsr_q, 1'b0);
    assign pay_sym  = raw_sym ^ lfsr_adv[3:0];

    // reseed on every frame start, advance one symbol per payload slot
    always_ff @(posedge CLK_50M or negedge RST_n) begin
        if (!RST_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (frame_start || (tick && state_q == PAYLOAD)) begin
            lfsr_q <= lfsr_next(lfsr_q, frame_start);
        end
    end
`else
    assign pay_sym = raw_sym;
`endif

    // state register
    always_ff @(posedge CLK_50M or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // next symbol and frame bookkeeping, evaluated only on the tick cycle;
    // state names the kind of symbol the next tick will emit
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        seq_nxt     = seq_q;
        data_nxt    = sym_data;
        active_nxt  = tx_active;
        done_nxt    = 1'b0;
        under_nxt   = underrun;
        frame_start = 1'b0;
        src_ready   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        frame_start = 1'b1;
                        data_nxt    = SYM_PRE_EVEN;
                        active_nxt  = 1'b1;
                        cnt_nxt     = 8'd1;
                        state_nxt   = PREAMBLE;
                    end else begin
                        data_nxt   = SYM_IDLE;
                        active_nxt = 1'b0;
                    end
                end
                PREAMBLE: begin
                    // cnt 0 here only on a back-to-back frame entered from PAYLOAD
                    frame_start = (cnt_q == 8'd0);
                    data_nxt    = cnt_q[0] ? SYM_PRE_ODD : SYM_PRE_EVEN;
                    active_nxt  = 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        cnt_nxt   = 8'd0;
                        state_nxt = HEADER;
                    end else begin
                        cnt_nxt = cnt_q + 8'd1;
                    end
                end
                HEADER: begin
                    if (cnt_q == 8'd0) begin
                        data_nxt = seq_q[7:4];
                        cnt_nxt  = 8'd1;
                    end else begin
                        data_nxt  = seq_q[3:0];
                        cnt_nxt   = 8'd0;
                        state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    src_ready = 1'b1;
                    data_nxt  = pay_sym;
                    if (!src_valid) begin
                        under_nxt = 1'b1;
                    end
                    if (cnt_q == PAY_LAST) begin
                        done_nxt  = 1'b1;
                        seq_nxt   = seq_q + 8'd1;
                        cnt_nxt   = 8'd0;
                        state_nxt = start ? PREAMBLE : IDLE;
                    end else begin
                        cnt_nxt = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            endcase
            if (frame_start) begin
                under_nxt = 1'b0;
            end
        end
    end

    // registered outputs and counters; strobe trails the tick by one cycle
    always_ff @(posedge CLK_50M or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q     <= 8'd0;
            seq_q     <= 8'd0;
            sym_stb   <= 1'b0;
            sym_data  <= SYM_IDLE;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            cnt_q     <= cnt_nxt;
            seq_q     <= seq_nxt;
            sym_stb   <= tick;
            sym_data  <= data_nxt;
            tx_active <= active_nxt;
            tx_done   <= done_nxt;
            underrun  <= under_nxt;
        end
    end

endmodule

// File: tb/tb_qam16_frame_sched.sv
`timescale 1ns/1ps
module tb_qam16_frame_sched;

    localparam int CLK_DIV  = 4;
    localparam int PRE_LEN  = 4;
    localparam int PAY_LEN  = 3;

    logic       CLK_50M   = 1'b0;
    logic       RST_n     = 1'b0;
    logic       start     = 1'b0;
    logic       src_valid = 1'b0;
    logic [3:0] src_data  = 4'h0;
    logic       src_ready;
    logic       sym_stb;
    logic [3:0] sym_data;
    logic       tx_active;
    logic       tx_done;
    logic       underrun;

    int n_checks = 0;
    int n_fails  = 0;

    always #10 CLK_50M = ~CLK_50M;

    qam16_frame_sched #(
        .CLK_DIV      (CLK_DIV),
        .PREAMBLE_LEN (PRE_LEN),
        .PAYLOAD_LEN  (PAY_LEN)
    ) dut (
        .CLK_50M   (CLK_50M),
        .RST_n     (RST_n),
        .start     (start),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .sym_stb   (sym_stb),
        .sym_data  (sym_data),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .underrun  (underrun)
    );

    // one record per strobe: inputs held over the preceding tick, expected strobe outputs
    typedef struct {
        logic       st;
        logic       vld;
        logic [3:0] dat;
        logic [3:0] sym;
        logic       done;
        logic       act;
        logic       urun;
        logic       rdy;
        logic       fs;
        logic       pay;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] cap [0:127];

`ifdef QAM16_SCRAMBLER_EN
    logic [6:0] lfsr_m;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic add_frame(input logic [7:0] seq, input logic [11:0] pdat, input logic [2:0] pvld,
                             input logic st_hold, input logic st_last);
        logic       u;
        logic [3:0] d;
        logic       last;
        u = 1'b0;
        for (int k = 0; k < PRE_LEN; k++) begin
            vecs.push_back('{(k == 0) ? 1'b1 : st_hold, 1'b1, 4'h0, (k % 2 == 0) ? 4'h3 : 4'hC,
                             1'b0, 1'b1, 1'b0, 1'b0, (k == 0), 1'b0});
        end
        vecs.push_back('{st_hold, 1'b1, 4'h0, seq[7:4], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{st_hold, 1'b1, 4'h0, seq[3:0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int j = 0; j < PAY_LEN; j++) begin
            d    = pdat[4*j +: 4];
            u    = u | ~pvld[j];
            last = (j == PAY_LEN - 1);
            vecs.push_back('{last ? st_last : st_hold, pvld[j], d, pvld[j] ? d : 4'h0,
                             last, 1'b1, u, 1'b1, 1'b0, 1'b1});
        end
    endtask

    task automatic add_idle(input logic urun);
        vecs.push_back('{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, urun, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic wait_stb(output logic got, output logic rdy_seen);
        got      = 1'b0;
        rdy_seen = 1'b0;
        for (int c = 0; c < 4 * CLK_DIV && !got; c++) begin
            @(negedge CLK_50M);
            if (src_ready) rdy_seen = 1'b1;
            if (sym_stb) got = 1'b1;
        end
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            vec_t       v;
            logic [3:0] es;
            logic       got;
            logic       rdy_seen;
            v         = vecs[i];
            start     = v.st;
            src_valid = v.vld;
            src_data  = v.dat;
            es        = v.sym;
`ifdef QAM16_SCRAMBLER_EN
            if (v.fs) lfsr_m = 7'h7F;
            if (v.pay) begin
                for (int s = 0; s < 4; s++) lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
                es = es ^ lfsr_m[3:0];
            end
`endif
            wait_stb(got, rdy_seen);
            chk($sformatf("v%0d strobe", i), 32'(got), 32'd1);
            if (got) begin
                cap[i] = sym_data;
                chk($sformatf("v%0d sym_data", i), 32'(sym_data), 32'(es));
                chk($sformatf("v%0d tx_done", i), 32'(tx_done), 32'(v.done));
                chk($sformatf("v%0d tx_active", i), 32'(tx_active), 32'(v.act));
                chk($sformatf("v%0d underrun", i), 32'(underrun), 32'(v.urun));
                chk($sformatf("v%0d src_ready", i), 32'(rdy_seen), 32'(v.rdy));
            end
        end
    endtask

    // RST_n must be low on entry; checks reset outputs, releases, checks first strobe
    task automatic reset_release();
        int   n;
        logic seen;
        @(negedge CLK_50M);
        chk("outputs_in_reset", 32'({src_ready, sym_stb, sym_data, tx_active, tx_done, underrun}), 32'd0);
        RST_n = 1'b1;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 5 * CLK_DIV) begin
            @(posedge CLK_50M);
            n++;
            @(negedge CLK_50M);
            seen = sym_stb;
        end
        chk("first_stb_delay", 32'(n), 32'(CLK_DIV));
        chk("first_stb_data", 32'({sym_data, tx_active, tx_done}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_seen;

        // part 1: single frame, underrun frame with stray start pulses, idle hold
        add_frame(8'h00, 12'h321, 3'b111, 1'b0, 1'b0);   // 0..8
        add_idle(1'b0);                                  // 9
        add_frame(8'h01, 12'h351, 3'b101, 1'b1, 1'b0);   // 10..18
        add_idle(1'b1);                                  // 19
        add_idle(1'b1);                                  // 20
        // part 2: frame aborted by reset after its first payload symbol
        add_frame(8'h02, 12'h321, 3'b111, 1'b0, 1'b0);   // 21..29
        // part 3: start held, three back-to-back frames with seq restarted at 0
        add_frame(8'h00, 12'h321, 3'b111, 1'b1, 1'b1);   // 30..38
        add_frame(8'h01, 12'h456, 3'b111, 1'b1, 1'b1);   // 39..47
        add_frame(8'h02, 12'h789, 3'b111, 1'b1, 1'b0);   // 48..56
        add_idle(1'b0);                                  // 57
`ifdef QAM16_SCRAMBLER_EN
        // part 4: two frames of all-zero payload
        add_frame(8'h03, 12'h000, 3'b111, 1'b1, 1'b1);   // 58..66
        add_frame(8'h04, 12'h000, 3'b111, 1'b1, 1'b0);   // 67..75
        add_idle(1'b0);                                  // 76
`endif

        repeat (3) @(negedge CLK_50M);
        reset_release();
        run_vec(0, 20);

        run_vec(21, 27);
        repeat (2) @(negedge CLK_50M);
        RST_n = 1'b0;
        #1;
        chk("outputs_on_abort", 32'({src_ready, sym_stb, sym_data, tx_active, tx_done, underrun}), 32'd0);
        done_seen = 1'b0;
        repeat (6) begin
            @(negedge CLK_50M);
            if (tx_done) done_seen = 1'b1;
        end
        chk("no_done_after_abort", 32'(done_seen), 32'd0);
        start = 1'b0;
        reset_release();
        run_vec(30, 57);

`ifdef QAM16_SCRAMBLER_EN
        run_vec(58, 76);
        for (int j = 0; j < PAY_LEN; j++) begin
            chk($sformatf("scr_repeat%0d", j), 32'(cap[67 + PRE_LEN + 2 + j]), 32'(cap[58 + PRE_LEN + 2 + j]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
